// File: rtl/br_flow_mux_rr_bypass.sv
// ============================================================================
//  br_flow_mux_rr_bypass
//  Round-robin N:1 ready-valid mux with a 1-entry bypass buffer on the output.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module br_flow_mux_rr_bypass #(
   parameter  int NumFlows = 2,
   parameter  int Width    = 1,
   localparam int IdWidth  = $clog2(NumFlows)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output logic [NumFlows-1:0]                push_ready,
   input  logic [NumFlows-1:0]                push_valid,
   input  logic [NumFlows-1:0][Width-1:0]     push_data,
   input  logic                               pop_ready,
   output logic                               pop_valid,
   output logic [Width-1:0]                   pop_data,
   output logic [IdWidth-1:0]                 pop_flow_id
);

   logic                buf_valid_q, buf_valid_d;
   logic [Width-1:0]    buf_data_q;
   logic [IdWidth-1:0]  buf_id_q;
   logic [IdWidth-1:0]  last_grant_q, last_grant_d;

   logic [NumFlows-1:0] grant;
   logic [IdWidth-1:0]  win_id;
   logic [IdWidth-1:0]  scan_idx;
   logic                found;
   logic                any_req;
   logic                can_accept;
   logic                pushed;
   logic                buf_push;
   logic                buf_pop;

   // Scan upward from the flow after the last grant, wrapping at NumFlows.
   always_comb begin
      grant    = '0;
      win_id   = '0;
      scan_idx = '0;
      found    = 1'b0;
      for (int k = 1; k <= NumFlows; k++) begin
         scan_idx = IdWidth'((int'(last_grant_q) + k) % NumFlows);
         if (!found && push_valid[scan_idx]) begin
            found            = 1'b1;
            grant[scan_idx]  = 1'b1;
            win_id           = scan_idx;
         end
      end
   end

   // rst_n gates the request so no handshake can complete while in reset.
   assign any_req     = rst_n && (|push_valid);
   assign can_accept  = pop_ready || !buf_valid_q;
   assign pushed      = any_req && can_accept;
   assign push_ready  = pushed ? grant : '0;

   assign pop_valid   = buf_valid_q || any_req;
   assign pop_data    = buf_valid_q ? buf_data_q : push_data[win_id];
   assign pop_flow_id = buf_valid_q ? buf_id_q   : win_id;

   assign buf_push     = pushed && (!pop_ready || buf_valid_q);
   assign buf_pop      = pop_ready && buf_valid_q;
   assign buf_valid_d  = buf_push || (buf_valid_q && !buf_pop);
   assign last_grant_d = pushed ? win_id : last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_q  <= 1'b0;
         last_grant_q <= IdWidth'(NumFlows - 1);
      end else begin
         buf_valid_q  <= buf_valid_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Payload is qualified by buf_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (buf_push) begin
         buf_data_q <= push_data[win_id];
         buf_id_q   <= win_id;
      end
   end

   a_push_ready_onehot0 : assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(push_ready));

   a_pop_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_data) && $stable(pop_flow_id)));

endmodule

`default_nettype wire

// File: tb/tb_br_flow_mux_rr_bypass.sv
// ============================================================================
//  tb_br_flow_mux_rr_bypass
//  Directed scenarios plus randomized traffic against a queue-based model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_br_flow_mux_rr_bypass;

   localparam int N = 3;
   localparam int W = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          push_ready;
   logic [N-1:0]          push_valid;
   logic [N-1:0][W-1:0]   push_data;
   logic                  pop_ready;
   logic                  pop_valid;
   logic [W-1:0]          pop_data;
   logic [1:0]            pop_flow_id;

   int checks = 0;
   int errors = 0;

   typedef logic [W-1:0] data_q_t[$];
   typedef struct packed { logic [1:0] id; logic [W-1:0] data; } entry_t;

   br_flow_mux_rr_bypass #(.NumFlows(N), .Width(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_ready  (push_ready),
      .push_valid  (push_valid),
      .push_data   (push_data),
      .pop_ready   (pop_ready),
      .pop_valid   (pop_valid),
      .pop_data    (pop_data),
      .pop_flow_id (pop_flow_id)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; push_valid = 3'b010; push_data = '0; push_data[1] = 8'hA5; pop_ready = 1'b1;
      step();
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
      checks++; if (push_ready !== 3'b000) begin errors++; $display("FAIL reset_push_ready got %b want 000", push_ready); end
      rst_n = 1'b1; #4;
      checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL cut_pop_valid got %b want 1", pop_valid); end
      checks++; if (pop_data !== 8'hA5) begin errors++; $display("FAIL cut_pop_data got %h want a5", pop_data); end
      checks++; if (pop_flow_id !== 2'd1) begin errors++; $display("FAIL cut_pop_id got %0d want 1", pop_flow_id); end
      checks++; if (push_ready !== 3'b010) begin errors++; $display("FAIL cut_push_ready got %b want 010", push_ready); end
      step();
      // Pointer now sits at 1, so flow 2 wins next among all three.
      push_valid = 3'b111; push_data[0] = 8'h10; push_data[1] = 8'h20; push_data[2] = 8'h30; #4;
      checks++; if (push_ready !== 3'b100 || pop_flow_id !== 2'd2) begin
         errors++; $display("FAIL ptr_after_reset got ready=%b id=%0d want 100/2", push_ready, pop_flow_id); end
      step();
   endtask

   task automatic test_all_valid();
      logic [1:0] exp_id;
      for (int c = 0; c < 6; c++) begin
         exp_id = 2'(c % 3);
         #4;
         checks++; if (pop_flow_id !== exp_id || pop_data !== 8'h10 * (exp_id + 1)) begin
            errors++; $display("FAIL rr_seq[%0d] got id=%0d data=%h want id=%0d data=%h", c, pop_flow_id, pop_data, exp_id, 8'h10 * (exp_id + 1)); end
         checks++; if (push_ready !== (3'b001 << exp_id) || pop_valid !== 1'b1) begin
            errors++; $display("FAIL rr_ready[%0d] got %b/%b want %b/1", c, push_ready, pop_valid, 3'b001 << exp_id); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      pop_ready = 1'b0; push_valid = 3'b100; push_data[2] = 8'h7E; #4;
      checks++; if (push_ready !== 3'b100 || pop_data !== 8'h7E) begin
         errors++; $display("FAIL bp_accept got ready=%b data=%h want 100/7e", push_ready, pop_data); end
      step();
      push_valid = 3'b000;
      for (int c = 0; c < 4; c++) begin
         #4;
         checks++; if (push_ready !== 3'b000 || pop_valid !== 1'b1 || pop_data !== 8'h7E || pop_flow_id !== 2'd2) begin
            errors++; $display("FAIL bp_hold[%0d] got ready=%b v=%b data=%h id=%0d want 000/1/7e/2", c, push_ready, pop_valid, pop_data, pop_flow_id); end
         step();
      end
      pop_ready = 1'b1; push_valid = 3'b001; push_data[0] = 8'h11; #4;
      checks++; if (push_ready !== 3'b001 || pop_data !== 8'h7E || pop_flow_id !== 2'd2) begin
         errors++; $display("FAIL bp_release got ready=%b data=%h id=%0d want 001/7e/2", push_ready, pop_data, pop_flow_id); end
      step();
      pop_ready = 1'b0; push_valid = 3'b000; #4;
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h11 || pop_flow_id !== 2'd0) begin
         errors++; $display("FAIL bp_reload got v=%b data=%h id=%0d want 1/11/0", pop_valid, pop_data, pop_flow_id); end
   endtask

   task automatic test_stall();
      push_valid = 3'b011; push_data[0] = 8'h01; push_data[1] = 8'h02; pop_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #4;
         checks++; if (push_ready !== 3'b000 || pop_data !== 8'h11 || pop_flow_id !== 2'd0) begin
            errors++; $display("FAIL stall[%0d] got ready=%b data=%h id=%0d want 000/11/0", c, push_ready, pop_data, pop_flow_id); end
         step();
      end
      pop_ready = 1'b1; #4;
      checks++; if (push_ready !== 3'b010) begin errors++; $display("FAIL stall_order got ready=%b want 010", push_ready); end
      step();
      push_valid = 3'b001; #4;
      checks++; if (pop_data !== 8'h02 || pop_flow_id !== 2'd1 || push_ready !== 3'b001) begin
         errors++; $display("FAIL stall_pipe got data=%h id=%0d ready=%b want 02/1/001", pop_data, pop_flow_id, push_ready); end
      step();
      push_valid = 3'b000; #4;
      checks++; if (pop_data !== 8'h01 || pop_flow_id !== 2'd0 || pop_valid !== 1'b1) begin
         errors++; $display("FAIL stall_drain got data=%h id=%0d v=%b want 01/0/1", pop_data, pop_flow_id, pop_valid); end
      step();
   endtask

   task automatic test_reset_mid();
      pop_ready = 1'b0; push_valid = 3'b001; push_data[0] = 8'hC3;
      step();
      push_valid = 3'b111; #2;
      rst_n = 1'b0; #1;
      checks++; if (pop_valid !== 1'b0 || push_ready !== 3'b000) begin
         errors++; $display("FAIL rst_mid got v=%b ready=%b want 0/000", pop_valid, push_ready); end
      step();
      push_valid = 3'b000; pop_ready = 1'b1; rst_n = 1'b1; #4;
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_empty got v=%b want 0", pop_valid); end
      step();
      push_valid = 3'b100; push_data[2] = 8'h5A; #4;
      checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h5A || pop_flow_id !== 2'd2 || push_ready !== 3'b100) begin
         errors++; $display("FAIL rst_mid_after got v=%b data=%h id=%0d ready=%b want 1/5a/2/100", pop_valid, pop_data, pop_flow_id, push_ready); end
      step();
      push_valid = 3'b000;
   endtask

   task automatic test_random();
      data_q_t             sent[N];
      entry_t              mq[$];
      entry_t              head;
      int                  mptr;
      int                  win;
      int                  waitc[N];
      logic [N-1:0]        pv;
      logic [N-1:0][W-1:0] pd;
      logic [5:0]          seq[N];
      logic [N-1:0]        exp_pr;
      logic                exp_pv, any, can, empty, drain;
      logic [W-1:0]        got;

      pv = '0; pd = '0; mptr = N - 1;
      for (int i = 0; i < N; i++) begin seq[i] = '0; waitc[i] = 0; end
      push_valid = '0; rst_n = 1'b0; step(); rst_n = 1'b1;

      for (int cyc = 0; cyc < 10000; cyc++) begin
         drain = (cyc >= 9950);
         for (int i = 0; i < N; i++) begin
            if (!pv[i] && !drain && $urandom_range(0, 99) < 40) begin
               pv[i] = 1'b1; pd[i] = {2'(i), seq[i]}; seq[i] = seq[i] + 6'd1;
            end
         end
         push_valid = pv; push_data = pd;
         pop_ready = drain ? 1'b1 : ($urandom_range(0, 99) < 60);
         #4;

         any = |pv; win = -1;
         for (int k = 1; k <= N; k++) if (win < 0 && pv[(mptr + k) % N]) win = (mptr + k) % N;
         empty  = (mq.size() == 0);
         can    = pop_ready || empty;
         exp_pr = (any && can) ? (3'b001 << win) : 3'b000;
         exp_pv = !empty || any;
         head   = !empty ? mq[0] : entry_t'{2'(win < 0 ? 0 : win), pd[win < 0 ? 0 : win]};

         checks++; if (push_ready !== exp_pr) begin
            errors++; $display("FAIL rnd_push_ready cyc=%0d got %b want %b", cyc, push_ready, exp_pr); end
         checks++; if (pop_valid !== exp_pv) begin
            errors++; $display("FAIL rnd_pop_valid cyc=%0d got %b want %b", cyc, pop_valid, exp_pv); end
         if (exp_pv) begin
            checks++; if (pop_data !== head.data || pop_flow_id !== head.id) begin
               errors++; $display("FAIL rnd_pop cyc=%0d got data=%h id=%0d want %h/%0d", cyc, pop_data, pop_flow_id, head.data, head.id); end
         end

         for (int i = 0; i < N; i++) if (push_valid[i] && push_ready[i]) sent[i].push_back(pd[i]);
         if (pop_valid && pop_ready) begin
            checks++;
            if (pop_flow_id >= 2'(N) || sent[pop_flow_id].size() == 0) begin
               errors++; $display("FAIL rnd_sb_unexpected cyc=%0d id=%0d data=%h", cyc, pop_flow_id, pop_data);
            end else begin
               got = sent[pop_flow_id].pop_front();
               if (got !== pop_data) begin
                  errors++; $display("FAIL rnd_sb_order cyc=%0d id=%0d got %h want %h", cyc, pop_flow_id, pop_data, got); end
            end
         end

         if (any && can) begin
            for (int i = 0; i < N; i++) begin
               if (i == win) waitc[i] = 0;
               else if (pv[i]) begin
                  waitc[i]++;
                  checks++; if (waitc[i] > N - 1) begin
                     errors++; $display("FAIL rnd_starve cyc=%0d flow=%0d waited %0d want <= %0d", cyc, i, waitc[i], N - 1); end
               end
            end
         end

         if (!empty && pop_ready) void'(mq.pop_front());
         if (any && can) begin
            if (!(empty && pop_ready)) mq.push_back(entry_t'{2'(win), pd[win]});
            mptr = win;
         end
         pv = pv & ~exp_pr;
         for (int i = 0; i < N; i++) if (!pv[i]) waitc[i] = 0;
         step();
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (sent[i].size() != 0) begin
            errors++; $display("FAIL rnd_lost flow=%0d undelivered=%0d want 0", i, sent[i].size()); end
      end
   endtask

   initial begin
      push_valid = '0; push_data = '0; pop_ready = 1'b0;
      test_reset();
      test_all_valid();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/br_flow_mux_rr_bypass.md
# br_flow_mux_rr_bypass

Round-robin multiplexer that shares one ready-valid output flow among NumFlows ready-valid requesters. A 1-entry bypass buffer on the output gives zero cut-through latency, zero backpressure latency and a throughput of 1 transfer per cycle. It sits in front of a shared downstream pipeline stage or resource and tags every transfer with the index of its source flow.

## Interface
- NumFlows, default 2: number of push flows. Must be ≥ 2.
- Width, default 1: data width. Must be ≥ 1.
- IdWidth, derived as $clog2(NumFlows): width of pop_flow_id. Not overridable.

- clk, input, 1: single clock. All state is on the rising edge.
- rst_n, input, 1: reset. Asynchronous and active-low.
- push_ready, output, NumFlows: per-flow ready.
- push_valid, input, NumFlows: per-flow valid.
- push_data, input, NumFlows x Width: per-flow data.
- pop_ready, input, 1: downstream ready.
- pop_valid, output, 1: output valid.
- pop_data, output, Width: output data.
- pop_flow_id, output, IdWidth: index of the flow that pop_data came from.

## Operation
- **State**
  - buf_valid, buf_data, buf_id: the 1-entry buffer.
  - last_grant: IdWidth-bit round-robin pointer.
- **Arbitration (combinational)**
  - The winner is the first flow with push_valid set, scanning (last_grant+1) mod NumFlows upward and wrapping.
  - any_req = OR of push_valid.
  - At most one grant bit is set.
- **Push side**
  - can_accept = pop_ready || !buf_valid.
  - push_ready[i] = grant[i] && can_accept. A non-winning flow never sees ready.
  - pushed = any_req && can_accept.
- **Pop side**
  - pop_valid = buf_valid || any_req.
  - pop_data / pop_flow_id = buf_data / buf_id when buf_valid; otherwise the winner's push_data and index.
- **Buffer updates**
  - buf_push = pushed && (!pop_ready || buf_valid). This covers two cases: backpressured while empty, or pipelined while full.
  - buf_pop = pop_ready && buf_valid.
  - buf_valid_next = buf_push || (buf_valid && !buf_pop).
  - buf_data and buf_id load only on buf_push. They are not reset and are qualified by buf_valid.
- **Pointer**
  - last_grant updates to the winner index only on pushed.
  - It holds on stalls, so the winner stays stable while push_valid inputs are stable.
- **Reset values**
  - buf_valid = 0.
  - last_grant = NumFlows-1, so flow 0 has highest priority first.
  - While rst_n = 0, all push_ready = 0 and pop_valid = 0, regardless of push_valid.
- **Reset asserted mid-operation**
  - A buffered entry is discarded immediately (asynchronously).
  - The pointer returns to NumFlows-1.
  - No handshakes complete while in reset.
- **Integration assertions**
  - push_valid[i] and push_data[i] are stable while push_valid[i] && !push_ready[i].
  - pop_valid and pop_data are stable under backpressure.
  - onehot0(push_ready).
  - At most one transfer per cycle on each side.

## Timing
- Cut-through latency: 0 cycles (push_valid to pop_valid) when buf_valid = 0.
- Backpressure latency: 0 cycles; pop_ready combinationally drives push_ready.
- Backpressured push: the data appears on pop_data from the buffer in the next cycle and holds until pop_ready.
- Full with pop_ready = 1: buffer pops and reloads with the new winner in the same cycle, giving 1 transfer per cycle.
- Fairness: with k flows continuously valid, each flow is granted once every k accepted transfers. Maximum wait is NumFlows-1 transfers.
- Pointer wrap: a grant to flow NumFlows-1 makes flow 0 the highest priority next.
- Combinational paths:
  - push_valid → pop_valid, pop_data, pop_flow_id, push_ready of all flows.
  - pop_ready → push_ready.
- No path from pop_ready to pop_valid.

## Test plan
- **Reset, single flow.** NumFlows=3, Width=8. Deassert rst_n; drive push_valid=3'b010, data[1]=8'hA5, pop_ready=1.
  - Same cycle: pop_valid=1, pop_data=A5, pop_flow_id=1, push_ready=3'b010.
  - Next cycle: last_grant=1.
- **All flows valid.** All three flows continuously valid with data 8'h10/8'h20/8'h30, pop_ready=1 for 6 cycles.
  - Pop sequence: flow ids 0,1,2,0,1,2.
  - Pop data: 10,20,30,10,20,30.
  - One transfer per cycle.
- **Backpressure fill and drain.** pop_ready=0; only flow 2 valid with data 8'h7E.
  - Cycle 0: push_ready[2]=1 and the entry is accepted into the buffer.
  - Cycle 1: push_ready=0, pop_valid=1, pop_data=7E, pop_flow_id=2.
  - Hold 3 cycles, then raise pop_ready: 7E pops, and a new flow 0 request is pipelined into the buffer that same cycle.
- **Stall stability.** Buffer full, pop_ready=0, flows 0 and 1 valid.
  - pop_data and pop_flow_id are unchanged each cycle.
  - last_grant is unchanged.
  - Flow 0 is not granted ahead of the pending order after release.
- **Reset mid-operation.** Assert rst_n=0 asynchronously with buf_valid=1 (data 8'hC3).
  - pop_valid=0 and push_ready=0 immediately.
  - After release with no push_valid: pop_valid=0, and the next single request from flow 2 is popped as flow id 2 with its own data, not C3.
- **Random stress.** Random push_valid (held stable while unaccepted) and random pop_ready over 10k cycles.
  - The scoreboard sees per-flow in-order, lossless delivery with correct pop_flow_id.
  - No flow starves beyond NumFlows-1 grants to others.
